// File: rtl/fetch_pkg.sv
// Shared types and constants for the instruction-fetch stage.
package fetch_pkg;

  typedef enum logic {
    BOOT = 1'b0,
    RUN  = 1'b1
  } fetch_state_t;

  localparam int unsigned PKT_XLEN    = 32;
  localparam int unsigned INSTR_BYTES = 4;
  localparam logic [31:0] NOP_INSTR   = 32'h0000_0013;

  typedef struct packed {
    logic [PKT_XLEN-1:0] pc;
    logic [31:0]         instr;
  } fetch_pkt_t;

endpackage

// File: rtl/fetch_skid_buf.sv
// One-entry skid buffer between the memory response and the decode output register.
// Forwards the oldest available packet to the output register whenever it is free.
module fetch_skid_buf
  import fetch_pkg::*;
(
  input  logic       clk,
  input  logic       reset,
  input  logic       i_flush,
  input  logic       i_rsp_valid,
  input  fetch_pkt_t i_rsp_pkt,
  input  logic       i_out_free,
  output logic       o_skid_valid,
  output logic       o_fwd_valid,
  output fetch_pkt_t o_fwd_pkt
);

  logic       r_valid;
  fetch_pkt_t r_pkt;
  logic       w_drain;
  logic       w_direct;
  logic       w_push;

  // A held entry is always older than a fresh response, so it drains first.
  assign w_drain  = r_valid && i_out_free;
  assign w_direct = i_rsp_valid && i_out_free && !r_valid;
  assign w_push   = i_rsp_valid && !w_direct;

  assign o_skid_valid = r_valid;
  assign o_fwd_valid  = w_drain || w_direct;
  assign o_fwd_pkt    = r_valid ? r_pkt : i_rsp_pkt;

  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      r_valid <= 1'b0;
    end else if (i_flush) begin
      r_valid <= 1'b0;
    end else if (w_push) begin
      r_valid <= 1'b1;
    end else if (w_drain) begin
      r_valid <= 1'b0;
    end
  end

  always_ff @(posedge clk) begin
    if (w_push && !i_flush) begin
      r_pkt <= i_rsp_pkt;
    end
  end

endmodule

// File: rtl/pc_fetch_unit.sv
// Instruction-fetch stage: PC, sequential fetch, redirect/squash, valid/ready output.
// Optional misaligned-redirect trap enabled by defining MISALIGN_TRAP_EN.
module pc_fetch_unit
  import fetch_pkg::*;
#(
  parameter int unsigned     XLEN     = 32,
  parameter logic [XLEN-1:0] RESET_PC = '0,
  parameter logic [XLEN-1:0] TRAP_VEC = XLEN'(32'h0000_0100)
) (
  input  logic            clk,
  input  logic            reset,
  input  logic            pc_sel,
  input  logic [XLEN-1:0] branch_target,
  output logic            imem_req,
  output logic [XLEN-1:0] imem_addr,
  input  logic [31:0]     imem_rdata,
  output logic            if_valid,
  input  logic            if_ready,
  output logic [XLEN-1:0] if_pc,
  output logic [31:0]     if_instr,
  output logic            misalign_trap
);

  fetch_state_t    r_state;
  fetch_state_t    w_state_nxt;
  logic [XLEN-1:0] r_pc;
  logic [XLEN-1:0] r_inflight_pc;
  logic            r_inflight;
  logic            r_if_valid;
  logic [XLEN-1:0] r_if_pc;
  logic [31:0]     r_if_instr;

  logic            w_issue;
  logic            w_redirect;
  logic [XLEN-1:0] w_redirect_pc;
  logic            w_out_free;
  logic            w_rsp_valid;
  fetch_pkt_t      w_rsp_pkt;
  logic            w_skid_valid;
  logic            w_fwd_valid;
  fetch_pkt_t      w_fwd_pkt;

  assign w_redirect  = (r_state == RUN) && pc_sel;
  assign w_out_free  = !r_if_valid || if_ready;
  assign w_rsp_valid = r_inflight && !w_redirect;
  assign w_rsp_pkt.pc    = r_inflight_pc;
  assign w_rsp_pkt.instr = imem_rdata;

`ifdef MISALIGN_TRAP_EN
  logic w_misaligned;
  assign w_misaligned  = |branch_target[1:0];
  assign w_redirect_pc = w_misaligned ? TRAP_VEC : branch_target;
  assign misalign_trap = w_redirect && w_misaligned;
`else
  logic w_unused;
  assign w_unused      = ^{branch_target[1:0], TRAP_VEC};
  assign w_redirect_pc = {branch_target[XLEN-1:2], 2'b00};
  assign misalign_trap = 1'b0;
`endif

  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      r_state <= BOOT;
    end else begin
      r_state <= w_state_nxt;
    end
  end

  // Stop fetching while the only free slot (skid) is already committed to the in-flight word.
  always_comb begin
    w_state_nxt = r_state;
    w_issue     = 1'b0;
    case (r_state)
      BOOT:    w_state_nxt = RUN;
      RUN:     w_issue = !pc_sel && !w_skid_valid && !(r_inflight && r_if_valid && !if_ready);
      default: w_state_nxt = BOOT;
    endcase
  end

  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      r_pc       <= RESET_PC;
      r_inflight <= 1'b0;
    end else if (w_redirect) begin
      r_pc       <= w_redirect_pc;
      r_inflight <= 1'b0;
    end else if (w_issue) begin
      r_pc       <= r_pc + XLEN'(INSTR_BYTES);
      r_inflight <= 1'b1;
    end else begin
      r_inflight <= 1'b0;
    end
  end

  always_ff @(posedge clk) begin
    if (w_issue) begin
      r_inflight_pc <= r_pc;
    end
  end

  fetch_skid_buf u_skid (
    .clk          (clk),
    .reset        (reset),
    .i_flush      (w_redirect),
    .i_rsp_valid  (w_rsp_valid),
    .i_rsp_pkt    (w_rsp_pkt),
    .i_out_free   (w_out_free),
    .o_skid_valid (w_skid_valid),
    .o_fwd_valid  (w_fwd_valid),
    .o_fwd_pkt    (w_fwd_pkt)
  );

  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      r_if_valid <= 1'b0;
      r_if_pc    <= '0;
      r_if_instr <= '0;
    end else if (w_redirect) begin
      r_if_valid <= 1'b0;
    end else if (w_fwd_valid) begin
      r_if_valid <= 1'b1;
      r_if_pc    <= w_fwd_pkt.pc;
      r_if_instr <= w_fwd_pkt.instr;
    end else if (if_ready) begin
      r_if_valid <= 1'b0;
    end
  end

  assign imem_req  = w_issue;
  assign imem_addr = r_pc;
  assign if_valid  = r_if_valid;
  assign if_pc     = r_if_pc;
  assign if_instr  = r_if_instr;

endmodule

// File: doc/pc_fetch_unit.md
Name: pc_fetch_unit

Overview:
Instruction-fetch stage that sits directly downstream of branch_controller and consumes its pc_sel decision.
- Holds the program counter and issues sequential requests to a synchronous instruction memory with 1-cycle read latency.
- Redirects to branch_target when pc_sel=1 and squashes wrong-path fetches.
- Delivers {pc, instr} to decode over a valid/ready handshake, with a one-entry skid buffer so backpressure never drops a fetched word.

Parameters:
XLEN, 32, address/data width
RESET_PC, 32'h0000_0000, PC value loaded on reset
TRAP_VEC, 32'h0000_0100, redirect address for a misaligned target (only with MISALIGN_TRAP_EN)

Ports:
clk  in  1  clock, all state on rising edge
reset  in  1  asynchronous, active-high reset
pc_sel  in  1  redirect request from branch_controller (1 = take branch_target)
branch_target  in  XLEN  redirect address, valid when pc_sel=1
imem_req  out  1  fetch request this cycle
imem_addr  out  XLEN  fetch address (= pc)
imem_rdata  in  32  instruction, valid the cycle after imem_req
if_valid  out  1  fetched instruction available to decode
if_ready  in  1  decode accepts when if_valid && if_ready
if_pc  out  XLEN  PC of the presented instruction
if_instr  out  32  presented instruction
misalign_trap  out  1  one-cycle pulse on a misaligned redirect (MISALIGN_TRAP_EN only; tied 0 otherwise)

Behaviour:
- Reset, asynchronous:
  - pc=RESET_PC, state=BOOT, inflight=0, skid_valid=0, if_valid=0.
  - if_pc=0, if_instr=0, imem_req=0, misalign_trap=0.
- FSM:
  - BOOT: no request; goes to RUN on the first clock edge after reset deasserts.
  - RUN: steady state. No other states.
- Issue condition (RUN): imem_req = !pc_sel && !skid_valid && !(inflight && if_valid && !if_ready).
  - On issue: inflight<=1, inflight_pc<=pc, pc<=pc+4. The add wraps modulo 2^XLEN.
  - imem_addr is always pc, combinationally.
- Response: when inflight, imem_rdata is valid this cycle and is tagged with inflight_pc.
  - Goes to the output register if the register is empty or is being consumed (!if_valid || if_ready) and the skid is empty.
  - Otherwise goes to the skid buffer.
- Skid drain: if skid_valid && (!if_valid || if_ready), the skid moves to the output register and skid_valid<=0. The skid always has priority over a fresh response; ordering is preserved.
- Output register: if_valid/if_pc/if_instr hold stable while if_valid && !if_ready. if_valid falls after a handshake if there is no replacement.
- Redirect (pc_sel=1 in RUN), highest priority over all of the above:
  - pc<=branch_target; no request this cycle.
  - inflight response is discarded; inflight<=0.
  - skid_valid<=0, if_valid<=0. A handshake that completes in the same cycle still counts as consumed.
- Redirect latency: target request the cycle after pc_sel; if_valid with if_pc=target two cycles after pc_sel.
- pc_sel in BOOT: ignored; the reset PC stands.
- Throughput: one instruction per cycle with if_ready held high.
- Reset mid-stream: everything clears immediately; the memory response in flight is ignored.

Optional Feature:
MISALIGN_TRAP_EN:
- Defined: a redirect with branch_target[1:0]!=0 sets pc<=TRAP_VEC and pulses misalign_trap for one cycle, coincident with pc_sel.
- Undefined: branch_target[1:0] is forced to 2'b00, no trap logic exists, and misalign_trap is tied 0.

Decomposition:
- Package fetch_pkg:
  - fetch_state_t enum {BOOT, RUN}.
  - Constants INSTR_BYTES=4, NOP_INSTR=32'h0000_0013.
  - Packed struct fetch_pkt_t {pc, instr}.
- Sub-module fetch_skid_buf: a one-entry skid buffer holding fetch_pkt_t with its valid/ready logic. The FSM and PC logic stay in the top level.

Test Plan:
- Reset with RESET_PC=0, if_ready=1 -> requests at 0,4,8,... from the cycle after BOOT; if_valid first rises 2 cycles after reset release with if_pc=0, then one instruction per cycle.
- Backpressure: if_ready=0 for 3 cycles while streaming -> if_pc held at 0x8, skid holds 0xC, no request issued; when if_ready=1 returns, 0x8, 0xC, 0x10 delivered in order with no loss or duplicate.
- Redirect: pc_sel=1, branch_target=0x40 while 0x10 is in flight -> 0x10 never appears; imem_addr=0x40 the next cycle; if_pc=0x40 two cycles after pc_sel.
- Redirect during stall: skid and output full, pc_sel=1, target=0x80 -> both entries squashed; the next delivered if_pc is 0x80.
- Wrap: pc=0xFFFF_FFFC -> next request address 0x0000_0000.
- With MISALIGN_TRAP_EN: target=0x42 -> misalign_trap pulses 1 cycle and the next if_pc is 0x100. Without it: the next if_pc is 0x40.
